// File: rtl/health_manager.sv
// Authoritative fighter health, hit/invulnerability handling and KO/round-end sequencing.
// Optional regeneration is built when HEALTH_REGEN_EN is defined.
module health_manager #(
  parameter logic [8:0]  MAX_HEALTH     = 9'd300,
  parameter logic [31:0] INVULN_CYCLES  = 32'd25_000_000,
  parameter logic [31:0] KO_HOLD_CYCLES = 32'd200_000_000,
  parameter int unsigned CHIP_SHIFT     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       round_start,
  input  logic       hit_l,
  input  logic [7:0] dmg_l,
  input  logic       blocked_l,
  input  logic       hit_r,
  input  logic [7:0] dmg_r,
  input  logic       blocked_r,
  input  logic [8:0] final_health_l,
  input  logic [8:0] final_health_r,
  output logic [8:0] curr_health_l,
  output logic [8:0] curr_health_r,
  output logic       hit_ack_l,
  output logic       hit_ack_r,
  output logic       ko,
  output logic [1:0] winner,
  output logic       round_over
);

  typedef enum logic [2:0] {
    IDLE, FIGHT, DRAIN, KO_HOLD, OVER
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  hl_q, hl_d, hr_q, hr_d;
  logic [31:0] inv_l_q, inv_l_d;
  logic [31:0] inv_r_q, inv_r_d;
  logic [31:0] hold_q, hold_d;
  logic        ko_q, ko_d;
  logic [1:0]  win_q, win_d;
  logic        ro_q, ro_d;
  logic        ack_l_q, ack_l_d;
  logic        ack_r_q, ack_r_d;
  logic        acc_l, acc_r;
  logic [7:0]  eff_l, eff_r;
  logic [9:0]  dif_l, dif_r;

`ifdef HEALTH_REGEN_EN
  logic [23:0] idle_l_q, idle_l_d;
  logic [23:0] idle_r_q, idle_r_d;
`endif

  // Blocked hits still chip at least one point unless dmg is zero.
  function automatic logic [7:0] eff_f(
    input logic [7:0] d,
    input logic       b
  );
    logic [7:0] s;
    s = d >> CHIP_SHIFT;
    if (!b)
      eff_f = d;
    else if (s == 8'd0 && d != 8'd0)
      eff_f = 8'd1;
    else
      eff_f = s;
  endfunction

  always_comb begin
    acc_l = (state_q == FIGHT) && hit_l && (inv_l_q == 32'd0);
    acc_r = (state_q == FIGHT) && hit_r && (inv_r_q == 32'd0);
    eff_l = eff_f(dmg_l, blocked_l);
    eff_r = eff_f(dmg_r, blocked_r);
    dif_l = {1'b0, hl_q} - {2'b00, eff_l};
    dif_r = {1'b0, hr_q} - {2'b00, eff_r};
  end

  always_comb begin
    state_d = state_q;
    hl_d    = hl_q;
    hr_d    = hr_q;
    inv_l_d = (inv_l_q != 32'd0) ? inv_l_q - 32'd1 : 32'd0;
    inv_r_d = (inv_r_q != 32'd0) ? inv_r_q - 32'd1 : 32'd0;
    hold_d  = hold_q;
    ko_d    = ko_q;
    win_d   = win_q;
    ro_d    = 1'b0;
    ack_l_d = 1'b0;
    ack_r_d = 1'b0;
`ifdef HEALTH_REGEN_EN
    idle_l_d = 24'd0;
    idle_r_d = 24'd0;
    if (state_q == FIGHT) begin
      idle_l_d = acc_l ? 24'd0 : idle_l_q + 24'd1;
      idle_r_d = acc_r ? 24'd0 : idle_r_q + 24'd1;
      if (!acc_l && idle_l_q == '1 &&
          hl_q != 9'd0 && hl_q < MAX_HEALTH)
        hl_d = hl_q + 9'd1;
      if (!acc_r && idle_r_q == '1 &&
          hr_q != 9'd0 && hr_q < MAX_HEALTH)
        hr_d = hr_q + 9'd1;
    end
`endif
    if (acc_l) begin
      hl_d    = dif_l[9] ? 9'd0 : dif_l[8:0];
      inv_l_d = INVULN_CYCLES;
      ack_l_d = 1'b1;
    end
    if (acc_r) begin
      hr_d    = dif_r[9] ? 9'd0 : dif_r[8:0];
      inv_r_d = INVULN_CYCLES;
      ack_r_d = 1'b1;
    end
    case (state_q)
      IDLE, OVER: begin
        if (round_start) begin
          state_d = FIGHT;
          hl_d    = MAX_HEALTH;
          hr_d    = MAX_HEALTH;
          ko_d    = 1'b0;
          win_d   = 2'b00;
          inv_l_d = 32'd0;
          inv_r_d = 32'd0;
        end
      end
      FIGHT: begin
        if (hl_q == 9'd0 || hr_q == 9'd0) begin
          state_d = DRAIN;
          ko_d    = 1'b1;
          win_d   = {hl_q == 9'd0, hr_q == 9'd0};
        end
      end
      DRAIN: begin
        if (final_health_l == hl_q &&
            final_health_r == hr_q) begin
          state_d = KO_HOLD;
          hold_d  = KO_HOLD_CYCLES;
        end
      end
      KO_HOLD: begin
        if (hold_q <= 32'd1) begin
          state_d = OVER;
          hold_d  = 32'd0;
          ro_d    = 1'b1;
        end else begin
          hold_d  = hold_q - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      hl_q     <= MAX_HEALTH;
      hr_q     <= MAX_HEALTH;
      inv_l_q  <= 32'd0;
      inv_r_q  <= 32'd0;
      hold_q   <= 32'd0;
      ko_q     <= 1'b0;
      win_q    <= 2'b00;
      ro_q     <= 1'b0;
      ack_l_q  <= 1'b0;
      ack_r_q  <= 1'b0;
`ifdef HEALTH_REGEN_EN
      idle_l_q <= 24'd0;
      idle_r_q <= 24'd0;
`endif
    end else begin
      state_q  <= state_d;
      hl_q     <= hl_d;
      hr_q     <= hr_d;
      inv_l_q  <= inv_l_d;
      inv_r_q  <= inv_r_d;
      hold_q   <= hold_d;
      ko_q     <= ko_d;
      win_q    <= win_d;
      ro_q     <= ro_d;
      ack_l_q  <= ack_l_d;
      ack_r_q  <= ack_r_d;
`ifdef HEALTH_REGEN_EN
      idle_l_q <= idle_l_d;
      idle_r_q <= idle_r_d;
`endif
    end
  end

  assign curr_health_l = hl_q;
  assign curr_health_r = hr_q;
  assign hit_ack_l     = ack_l_q;
  assign hit_ack_r     = ack_r_q;
  assign ko            = ko_q;
  assign winner        = win_q;
  assign round_over    = ro_q;

endmodule

// File: tb/tb_health_manager.sv
// Bench for health_manager: directed round scenarios, then randomized rounds
// checked against a cycle-level behavioural model of the round rules.
module tb_health_manager;

  localparam int MAXH = 100;
  localparam int INV  = 4;
  localparam int HOLD = 8;
  localparam int CHIP = 2;

  localparam int P_IDLE  = 0;
  localparam int P_FIGHT = 1;
  localparam int P_DRAIN = 2;
  localparam int P_HOLD  = 3;
  localparam int P_OVER  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       round_start = 1'b0;
  logic       hit_l = 1'b0, hit_r = 1'b0;
  logic [7:0] dmg_l = '0, dmg_r = '0;
  logic       blocked_l = 1'b0, blocked_r = 1'b0;
  logic [8:0] final_health_l = 9'd300;
  logic [8:0] final_health_r = 9'd300;
  logic [8:0] curr_health_l, curr_health_r;
  logic       hit_ack_l, hit_ack_r, ko, round_over;
  logic [1:0] winner;

  always #5 clk = ~clk;

  health_manager #(
    .MAX_HEALTH(9'(MAXH)),
    .INVULN_CYCLES(32'(INV)),
    .KO_HOLD_CYCLES(32'(HOLD)),
    .CHIP_SHIFT(CHIP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .round_start(round_start),
    .hit_l(hit_l),
    .dmg_l(dmg_l),
    .blocked_l(blocked_l),
    .hit_r(hit_r),
    .dmg_r(dmg_r),
    .blocked_r(blocked_r),
    .final_health_l(final_health_l),
    .final_health_r(final_health_r),
    .curr_health_l(curr_health_l),
    .curr_health_r(curr_health_r),
    .hit_ack_l(hit_ack_l),
    .hit_ack_r(hit_ack_r),
    .ko(ko),
    .winner(winner),
    .round_over(round_over)
  );

  int tests = 0;
  int fails = 0;

  // Model: phase, healths, timestamps of last accepted hits
  int ph = P_IDLE;
  int m_hl = MAXH, m_hr = MAXH;
  int m_ko = 0, m_win = 0;
  int m_ack_l = 0, m_ack_r = 0, m_ro = 0;
  int hold_left = 0;
  int cyc = 0;
  int last_l = -100, last_r = -100;
  int ro_cnt;

  function automatic int eff_dmg(int d, bit b);
    int e;
    if (!b) return d;
    e = d / (1 << CHIP);
    if (d != 0 && e == 0) e = 1;
    return e;
  endfunction

  task automatic model_cycle();
    int e;
    m_ack_l = 0;
    m_ack_r = 0;
    m_ro    = 0;
    if (reset) begin
      ph = P_IDLE;
      m_hl = MAXH;
      m_hr = MAXH;
      m_ko = 0;
      m_win = 0;
      last_l = -100;
      last_r = -100;
      hold_left = 0;
      return;
    end
    case (ph)
      P_IDLE, P_OVER: begin
        if (round_start) begin
          ph = P_FIGHT;
          m_hl = MAXH;
          m_hr = MAXH;
          m_ko = 0;
          m_win = 0;
          last_l = -100;
          last_r = -100;
        end
      end
      P_FIGHT: begin
        if (m_hl == 0 || m_hr == 0) begin
          m_win = (m_hl == 0 ? 2 : 0) + (m_hr == 0 ? 1 : 0);
          m_ko = 1;
          ph = P_DRAIN;
        end
        if (hit_l && (cyc - last_l) > INV) begin
          e = eff_dmg(int'(dmg_l), blocked_l);
          m_hl = (m_hl > e) ? m_hl - e : 0;
          m_ack_l = 1;
          last_l = cyc;
        end
        if (hit_r && (cyc - last_r) > INV) begin
          e = eff_dmg(int'(dmg_r), blocked_r);
          m_hr = (m_hr > e) ? m_hr - e : 0;
          m_ack_r = 1;
          last_r = cyc;
        end
      end
      P_DRAIN: begin
        if (int'(final_health_l) == m_hl &&
            int'(final_health_r) == m_hr) begin
          ph = P_HOLD;
          hold_left = HOLD;
        end
      end
      P_HOLD: begin
        hold_left--;
        if (hold_left == 0) begin
          ph = P_OVER;
          m_ro = 1;
        end
      end
      default: ph = P_IDLE;
    endcase
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    cyc++;
    chk("hl", 32'(curr_health_l), 32'(m_hl));
    chk("hr", 32'(curr_health_r), 32'(m_hr));
    chk("ack_l", 32'(hit_ack_l), 32'(m_ack_l));
    chk("ack_r", 32'(hit_ack_r), 32'(m_ack_r));
    chk("ko", 32'(ko), 32'(m_ko));
    chk("winner", 32'(winner), 32'(m_win));
    chk("round_over", 32'(round_over), 32'(m_ro));
    if (round_over) ro_cnt++;
    round_start = 1'b0;
    hit_l = 1'b0;
    hit_r = 1'b0;
    blocked_l = 1'b0;
    blocked_r = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [7:0] pick_dmg();
    case ($urandom_range(0, 5))
      0: return 8'($urandom_range(0, 3));
      1: return 8'($urandom_range(200, 255));
      default: return 8'($urandom_range(0, 60));
    endcase
  endfunction

  function automatic logic [8:0] drift(logic [8:0] f, int tgt);
    int v;
    v = int'(f);
    if (v > tgt) v = (v - tgt > 3) ? v - 3 : tgt;
    else if (v < tgt) v = (tgt - v > 3) ? v + 3 : tgt;
    return 9'(v);
  endfunction

  initial begin
    int n;
    // Reset state
    reset = 1'b1;
    step();
    chk("rst_hl_const", 32'(curr_health_l), 32'd100);
    chk("rst_ko_const", 32'(ko), 32'd0);
    reset = 1'b0;
    step();

    // Round start, first hit
    round_start = 1'b1;
    step();
    hit_l = 1'b1; dmg_l = 8'd30;
    step();
    chk("hit30_hl", 32'(curr_health_l), 32'd70);
    chk("hit30_ack", 32'(hit_ack_l), 32'd1);
    chk("hit30_hr", 32'(curr_health_r), 32'd100);
    step();
    chk("ack_pulse", 32'(hit_ack_l), 32'd0);
    idle(4);

    // Invulnerability window and its boundary
    hit_l = 1'b1; dmg_l = 8'd10;
    step();
    chk("inv_first", 32'(curr_health_l), 32'd60);
    step();
    hit_l = 1'b1; dmg_l = 8'd10;
    step();
    chk("inv_rej_ack", 32'(hit_ack_l), 32'd0);
    step();
    hit_l = 1'b1; dmg_l = 8'd10;
    step();
    chk("inv_edge_rej", 32'(curr_health_l), 32'd60);
    hit_l = 1'b1; dmg_l = 8'd10;
    step();
    chk("inv_after", 32'(curr_health_l), 32'd50);
    idle(5);

    // Blocked hits: chip damage and minimum of one
    hit_r = 1'b1; dmg_r = 8'd20; blocked_r = 1'b1;
    step();
    chk("blk20", 32'(curr_health_r), 32'd95);
    idle(5);
    hit_r = 1'b1; dmg_r = 8'd2; blocked_r = 1'b1;
    step();
    chk("blk2", 32'(curr_health_r), 32'd94);
    idle(5);
    hit_r = 1'b1; dmg_r = 8'd0; blocked_r = 1'b1;
    step();
    chk("dmg0_ack", 32'(hit_ack_r), 32'd1);
    idle(5);
    hit_r = 1'b1; dmg_r = 8'd79;
    step();
    chk("r15", 32'(curr_health_r), 32'd15);
    idle(5);

    // KO with saturating damage, then drain hand-off
    hit_r = 1'b1; dmg_r = 8'd40;
    step();
    chk("r_zero", 32'(curr_health_r), 32'd0);
    chk("ko_not_yet", 32'(ko), 32'd0);
    step();
    chk("ko_set", 32'(ko), 32'd1);
    chk("win_left", 32'(winner), 32'd1);
    final_health_l = 9'd50;
    final_health_r = 9'd50;
    idle(3);
    round_start = 1'b1;
    step();
    chk("rs_in_drain", 32'(ko), 32'd1);
    final_health_r = 9'd0;
    ro_cnt = 0;
    idle(12);
    chk("ro_once", 32'(ro_cnt), 32'd1);
    chk("over_ko_hold", 32'(ko), 32'd1);

    // Restart from OVER
    round_start = 1'b1;
    step();
    chk("restart_hl", 32'(curr_health_l), 32'd100);
    chk("restart_win", 32'(winner), 32'd0);

    // Same-cycle double KO
    hit_l = 1'b1; dmg_l = 8'd90;
    hit_r = 1'b1; dmg_r = 8'd90;
    step();
    idle(5);
    hit_l = 1'b1; dmg_l = 8'd50;
    hit_r = 1'b1; dmg_r = 8'd50;
    step();
    step();
    chk("draw_win", 32'(winner), 32'd3);
    chk("draw_ko", 32'(ko), 32'd1);

    // Reset while holding KO
    final_health_l = 9'd0;
    final_health_r = 9'd0;
    idle(3);
    reset = 1'b1;
    step();
    chk("rst_hold_hr", 32'(curr_health_r), 32'd100);
    chk("rst_hold_ko", 32'(ko), 32'd0);
    reset = 1'b0;
    step();

    // Randomized rounds
    for (int rnd = 0; rnd < 15; rnd++) begin
      round_start = 1'b1;
      step();
      n = 0;
      while (ph != P_OVER && n < 500) begin
        hit_l = ($urandom_range(0, 2) == 0);
        dmg_l = pick_dmg();
        blocked_l = 1'($urandom_range(0, 1));
        hit_r = ($urandom_range(0, 2) == 0);
        dmg_r = pick_dmg();
        blocked_r = 1'($urandom_range(0, 1));
        round_start = ($urandom_range(0, 30) == 0);
        final_health_l = drift(final_health_l, m_hl);
        final_health_r = drift(final_health_r, m_hr);
        step();
        n++;
      end
      tests++;
      assert (ph == P_OVER) else begin
        fails++;
        $error("FAIL round_timeout got=%0d exp=%0d", ph, P_OVER);
      end
      idle($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
